// File: rtl/pulse_rate_shaper_pkg.sv
// Shared types and constants for the pulse rate shaper.
package pulse_rate_shaper_pkg;

  // Gap timer width; wide enough for any legal GAP_CYCLES (1..255).
  localparam int unsigned PRS_GAP_W = 8;

  // Output sequencer states.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StEmit = 2'd1,
    StGap  = 2'd2
  } prs_state_t;

endpackage : pulse_rate_shaper_pkg

// File: rtl/pulse_rate_shaper.sv
// Pulse rate shaper: queues single-cycle event pulses in a saturating counter and re-issues
// them as single-cycle pulses spaced at least GAP_CYCLES+1 clocks apart, so a slower
// destination domain behind the toggle synchronizer observes every event.
module pulse_rate_shaper
  import pulse_rate_shaper_pkg::*;
#(
  parameter int unsigned CNT_W      = 4,
  parameter int unsigned GAP_CYCLES = 4
) (
  input  logic             clk_i,
  input  logic             arst_n_i,
  input  logic             evt_i,
  input  logic             clr_ovf_i,
  output logic             pulse_o,
  output logic [CNT_W-1:0] pending_o,
  output logic             busy_o,
  output logic             ovf_o
);

  // Elaboration-time parameter sanity.
  if (GAP_CYCLES < 1 || GAP_CYCLES > 255) begin : g_gap_range_err
    $error("pulse_rate_shaper: GAP_CYCLES must be in 1..255");
  end
  if (CNT_W < 1) begin : g_cnt_w_err
    $error("pulse_rate_shaper: CNT_W must be at least 1");
  end

  localparam logic [CNT_W-1:0]     CntMax  = '1;
  localparam logic [CNT_W-1:0]     CntOne  = CNT_W'(1);
  localparam logic [PRS_GAP_W-1:0] GapLoad = PRS_GAP_W'(GAP_CYCLES);
  localparam logic [PRS_GAP_W-1:0] GapOne  = PRS_GAP_W'(1);

  prs_state_t           state_q, state_d;
  logic [PRS_GAP_W-1:0] gap_q, gap_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 pulse_q, pulse_d;
  logic                 ovf_q, ovf_d;

  logic work_avail;
  logic enter_emit;
  logic drop;

  // A new event this cycle or a queued one is enough to start a pulse.
  assign work_avail = evt_i | (cnt_q != '0);

  // Sequencer next state and gap timer; flags the edge that enters EMIT.
  always_comb begin
    state_d    = state_q;
    gap_d      = gap_q;
    enter_emit = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (work_avail) begin
          state_d    = StEmit;
          enter_emit = 1'b1;
        end
      end
      StEmit: begin
        gap_d   = GapLoad;
        state_d = StGap;
      end
      StGap: begin
        gap_d = gap_q - GapOne;
        if (gap_q == GapOne) begin
          if (work_avail) begin
            state_d    = StEmit;
            enter_emit = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: begin
        state_d = StIdle;
        gap_d   = '0;
      end
    endcase
  end

  // Saturating pending counter. The pulse is charged on the edge entering EMIT; with an
  // empty counter that entry is only possible with evt_i high, so the two cancel out.
  always_comb begin
    cnt_d = cnt_q;
    drop  = 1'b0;
    unique case ({evt_i, enter_emit})
      2'b10: begin
        if (cnt_q == CntMax) begin
          drop = 1'b1;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      2'b01:   cnt_d = cnt_q - CntOne;
      default: cnt_d = cnt_q;
    endcase
  end

  // Sticky overflow: a drop in the same cycle as a clear keeps the flag set.
  always_comb begin
    ovf_d = ovf_q;
    if (drop) begin
      ovf_d = 1'b1;
    end else if (clr_ovf_i) begin
      ovf_d = 1'b0;
    end
  end

  // The registered pulse is high exactly while the sequencer sits in EMIT.
  assign pulse_d = enter_emit;

  // All state and registered outputs; reset discards every queued event immediately.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q <= StIdle;
      gap_q   <= '0;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
      ovf_q   <= ovf_d;
    end
  end

  assign pulse_o   = pulse_q;
  assign pending_o = cnt_q;
  assign ovf_o     = ovf_q;
  // Only flop outputs feed this OR.
  assign busy_o    = (state_q != StIdle) | (cnt_q != '0);

endmodule : pulse_rate_shaper
